blink64_mixcol_sched: RTL and testbench
=======================================

# blink64_mixcol_sched

Shared-resource scheduler for the 64-bit Blink diffusion layer (MixColumns).
- Arbitrates between two requesters (port 0, port 1) for a single MixColumns instance.
- Each accepted job iterates MixColumns on a registered 64-bit state a requested number of times.
- Returns the result, tagged with the requester id, on a valid/ready response channel.
- Sits between the round datapath and the tweak/key-schedule logic so both can reuse one diffusion unit.

## Interface

Parameters:
- CNT_W, 4, width of the per-job iteration count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  port 0 job request.
- req0_ready  out  1  port 0 job accepted this cycle.
- req0_data  in  64  port 0 initial state.
- req0_cnt  in  CNT_W  port 0 number of MixColumns applications (0 allowed).
- req1_valid, req1_ready, req1_data, req1_cnt  are identical to the port 0 signals, for port 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  64  result state.
- rsp_id  out  1  requester that issued the job.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation

MixColumns function (internal instance):
- Nibble k = bits [4k+3:4k].
- Column c (0..3) holds nibbles c, 4+c, 8+c, 12+c.
- Each output nibble is the XOR of the other three input nibbles of its column.
- The function is an involution.

FSM states are IDLE, RUN and DONE.

IDLE:
- Winner selection uses round-robin. The requester not served last has priority; if only one requester is valid, it wins.
- `last` resets to 1, so port 0 has priority first.
- reqX_ready = (state==IDLE) & winnerX. This is combinational from valid; at most one ready is high.
- On accept:
  - state_reg ← reqX_data; rem ← reqX_cnt; id ← X; last ← X.
  - Next state is RUN if cnt≠0, else DONE.

RUN:
- Every cycle: state_reg ← MC(state_reg); rem ← rem−1.
- When rem==1 (final application), next state is DONE.
- Requests are ignored (ready low) for the whole RUN.

DONE:
- rsp_valid=1. rsp_data=state_reg and rsp_id=id come directly from registers.
- All are held stable until rsp_ready.
- On rsp_valid & rsp_ready, go to IDLE.

Other rules:
- A requester is not required to hold valid while waiting. Once valid is asserted with ready low, data and cnt must stay stable.
- Count wraps are impossible: rem is only decremented in RUN, where rem≥1.
- Simultaneous valid requests never cause a double accept.

## Timing

Reset (rst_n low, asynchronous):
- FSM goes to IDLE; state_reg, rem and id go to 0; last goes to 1.
- Outputs: rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, req0_ready and req1_ready low unless the FSM is in IDLE with a valid request.
- Reset during RUN or DONE drops the job silently; no response is produced.

Latency and throughput:
- With the accept on edge E0 and cnt=k, rsp_valid rises after edge E0+k. For k=0 that is the cycle immediately after accept.
- The MixColumns path is combinational in one cycle between state_reg and state_reg.
- After the response handshake edge, the FSM spends one cycle in IDLE before the next accept. Minimum job period is k+2 cycles.
- busy rises the cycle after accept and falls the cycle after the response handshake.

## Test plan

- Single application: req0 data=0x0000000000000001, cnt=1, rsp_ready=1 → rsp_data=0x0001000100010000, rsp_id=0; rsp_valid one cycle after accept.
- Involution: req1 data=0x0123456789ABCDEF, cnt=2 → rsp_data=0x0123456789ABCDEF, rsp_id=1, two cycles after accept. With cnt=0 → same data, rsp_valid the cycle after accept.
- Arbitration: both ports valid continuously, cnt=1 each → accepts alternate port 0, 1, 0, 1; the first grant after reset goes to port 0; never two readys in one cycle.
- Backpressure: job cnt=3, rsp_ready held low 5 cycles after rsp_valid → rsp_data and rsp_id stable; req0_ready and req1_ready low; busy=1; the job completes on the first rsp_ready high.
- Reset mid-operation: assert rst_n low during RUN of a cnt=7 job → outputs zero immediately (asynchronous); no response after release; the next request is served by port 0 first.
- Max count: cnt=15 on data 0x0000000000000001 → result equals the cnt=1 result (odd count), 15 cycles after accept.

Source files
------------

// File: rtl/blink64_mixcol_sched_if.sv
// Handshake bundle for the Blink-64 MixColumns scheduler: two job request
// ports, one tagged response port, and the busy flag.
interface blink64_mixcol_sched_if #(
    parameter int CNT_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [63:0]      req0_data;
    logic [CNT_W-1:0] req0_cnt;
    logic             req1_valid;
    logic             req1_ready;
    logic [63:0]      req1_data;
    logic [CNT_W-1:0] req1_cnt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_data;
    logic             rsp_id;
    logic             busy;

    modport slave (
        input  req0_valid, req0_data, req0_cnt,
        input  req1_valid, req1_data, req1_cnt,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id, busy
    );

    modport master (
        output req0_valid, req0_data, req0_cnt,
        output req1_valid, req1_data, req1_cnt,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/blink64_mixcol_sched.sv
// Round-robin scheduler that shares one Blink-64 MixColumns unit between two
// requesters, iterating it a per-job number of times on a registered state.
//
// state | meaning
// IDLE  | waiting for a request; ready goes to the round-robin winner
// RUN   | applying MixColumns once per cycle, rem counts down to 1
// DONE  | result held on rsp_* until the consumer takes it
module blink64_mixcol_sched #(
    parameter int CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    blink64_mixcol_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           fsm_q, fsm_d;
    logic [63:0]      st_q, st_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    logic             win0, win1;
    logic [CNT_W-1:0] sel_cnt;

    // Each output nibble is the XOR of the other three nibbles in its column,
    // i.e. column parity XOR the nibble itself.
    function automatic logic [63:0] mix_col(input logic [63:0] s);
        logic [63:0] r;
        logic [3:0]  colx;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            colx = s[4*c +: 4] ^ s[4*(c+4) +: 4] ^ s[4*(c+8) +: 4] ^ s[4*(c+12) +: 4];
            for (int row = 0; row < 4; row++) begin
                r[4*(4*row+c) +: 4] = colx ^ s[4*(4*row+c) +: 4];
            end
        end
        return r;
    endfunction

    // last_q names the port served most recently; the other one has priority.
    assign win0 = bus.req0_valid & (~bus.req1_valid | last_q);
    assign win1 = bus.req1_valid & (~bus.req0_valid | ~last_q);

    assign bus.req0_ready = (fsm_q == IDLE) & win0;
    assign bus.req1_ready = (fsm_q == IDLE) & win1;

    assign sel_cnt = win1 ? bus.req1_cnt : bus.req0_cnt;

    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        rem_d  = rem_q;
        id_d   = id_q;
        last_d = last_q;
        case (fsm_q)
            IDLE: begin
                if (win0 | win1) begin
                    st_d   = win1 ? bus.req1_data : bus.req0_data;
                    rem_d  = sel_cnt;
                    id_d   = win1;
                    last_d = win1;
                    fsm_d  = (sel_cnt != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                st_d  = mix_col(st_q);
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        rsp_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            st_q        <= '0;
            rem_q       <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            st_q        <= st_d;
            rem_q       <= rem_d;
            id_q        <= id_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = st_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_blink64_mixcol_sched.sv
// Directed bench for the Blink-64 MixColumns scheduler with hand-computed
// results, latency, arbitration order, backpressure and mid-job reset.
module tb_blink64_mixcol_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    blink64_mixcol_sched_if #(.CNT_W(4)) bus ();

    blink64_mixcol_sched #(.CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] ONE     = 64'h0000_0000_0000_0001;
    localparam logic [63:0] ONE_MC  = 64'h0001_0001_0001_0000;
    localparam logic [63:0] AB      = 64'h0000_0000_0000_00AB;
    localparam logic [63:0] AB_MC   = 64'h00AB_00AB_00AB_0000;
    localparam logic [63:0] SEQ     = 64'h0123_4567_89AB_CDEF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one job with rsp_ready high and check readiness, latency, result.
    task automatic run_job(input bit port, input logic [63:0] d, input logic [3:0] c,
                           input logic [63:0] exp, input string tag);
        int n;
        if (port) begin
            bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_cnt = c;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_cnt = c;
        end
        #1;
        chk({tag, "_ready"}, {62'd0, bus.req1_ready, bus.req0_ready}, port ? 64'd2 : 64'd1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(c));
        chk({tag, "_data"}, bus.rsp_data, exp);
        chk({tag, "_id"}, 64'(bus.rsp_id), 64'(port));
        tick();
        chk({tag, "_idle"}, {62'd0, bus.busy, bus.rsp_valid}, 64'd0);
    endtask

    initial begin
        int n;
        bit seen;
        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_cnt = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_cnt = '0;
        bus.rsp_ready  = 1'b1;

        #12;
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", bus.rsp_data, 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_job(1'b0, ONE, 4'd1, ONE_MC, "single");
        run_job(1'b1, SEQ, 4'd2, SEQ, "invol_seq");
        run_job(1'b1, AB, 4'd2, AB, "invol_ab");
        run_job(1'b1, SEQ, 4'd0, SEQ, "cnt0");
        run_job(1'b0, ONE, 4'd15, ONE_MC, "max15");
        run_job(1'b1, AB, 4'd1, AB_MC, "ab_once");

        // Arbitration from reset: both ports hold valid, grants must alternate.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        bus.req0_valid = 1'b1; bus.req0_data = ONE; bus.req0_cnt = 4'd1;
        bus.req1_valid = 1'b1; bus.req1_data = AB;  bus.req1_cnt = 4'd1;
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(bus.req0_ready | bus.req1_ready) && n < 20) begin
                chk("arb_wait_onehot", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
                tick();
                n++;
            end
            chk("arb_onehot", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
            chk("arb_grant", {62'd0, bus.req1_ready, bus.req0_ready}, (g % 2 == 1) ? 64'd2 : 64'd1);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n = 0;
        while (bus.busy && n < 20) begin
            tick();
            n++;
        end
        chk("arb_drain", 64'(bus.busy), 64'd0);
        tick();

        // Backpressure: response held for five cycles, port 1 kept waiting.
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = AB; bus.req0_cnt = 4'd3;
        #1;
        chk("bp_ready", 64'(bus.req0_ready), 64'd1);
        tick();
        bus.req0_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("bp_latency", 64'(n), 64'd3);
        bus.req1_valid = 1'b1; bus.req1_data = ONE; bus.req1_cnt = 4'd1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_data", bus.rsp_data, AB_MC);
            chk("bp_id", 64'(bus.rsp_id), 64'd0);
            chk("bp_ready_low", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
            chk("bp_busy", 64'(bus.busy), 64'd1);
            tick();
        end
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        #1;
        chk("bp_still_valid", 64'(bus.rsp_valid), 64'd1);
        tick();
        chk("bp_released", {62'd0, bus.busy, bus.rsp_valid}, 64'd0);

        // Reset in the middle of a cnt=7 job drops it silently.
        bus.req0_valid = 1'b1; bus.req0_data = ONE; bus.req0_cnt = 4'd7;
        #1;
        chk("mid_ready", 64'(bus.req0_ready), 64'd1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        tick();
        chk("mid_running", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_data", bus.rsp_data, 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        #3;
        rst_n = 1'b1;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.rsp_valid || bus.busy) seen = 1'b1;
            tick();
        end
        chk("mid_no_rsp", 64'(seen), 64'd0);
        bus.req0_valid = 1'b1; bus.req0_data = SEQ; bus.req0_cnt = 4'd0;
        bus.req1_valid = 1'b1; bus.req1_data = AB;  bus.req1_cnt = 4'd0;
        #1;
        chk("mid_next_grant", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("mid_next_valid", 64'(bus.rsp_valid), 64'd1);
        chk("mid_next_data", bus.rsp_data, SEQ);
        chk("mid_next_id", 64'(bus.rsp_id), 64'd0);
        tick();
        chk("mid_next_idle", 64'(bus.busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
